// File: rtl/sram_controller.sv
// ---------------------------------------------------------------------------
// sram_controller
//
// Bridge between the pipeline MEM stage and an external 16-bit asynchronous
// SRAM. A 32-bit word read or write is split into two halfword SRAM cycles
// (low half first), followed by a fixed number of idle padding cycles and a
// one-cycle DONE state in which `ready` releases the pipeline freeze.
//
// Parameters:
//   BASE_ADDR    byte address that maps to SRAM word 0
//   WAIT_CYCLES  idle padding cycles after the two halfword accesses (>= 0)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   wr_en       write request, held until ready
//   rd_en       read request, held until ready (write wins if both set)
//   address     byte address of the word
//   write_data  store data
//   read_data   loaded word, registered, updated only by reads
//   ready       high when idle without request or in the DONE cycle
//   SRAM_DQ     SRAM data bus, driven only during write halfword cycles
//   SRAM_ADDR   SRAM halfword address, holds its last value between accesses
//   SRAM_WE_N   SRAM write strobe, active low
// ---------------------------------------------------------------------------
module sram_controller #(
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  logic [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N
);

    // Counter only needs to hold WAIT_CYCLES; keep at least one bit so the
    // WAIT_CYCLES=0 build still has a legal vector.
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        ACC_LO,
        ACC_HI,
        WAIT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_nxt;

    // Request captured in IDLE; inputs are ignored for the rest of the access.
    logic [16:0]        idx_q;
    logic [31:0]        wdata_q;
    logic               is_write_q;

    logic [17:0]        last_addr_q;

    logic [31:0]        offset;
    logic               in_acc;
    logic               hi_sel;
    logic               dq_oe;
    logic [15:0]        dq_out;
    logic               unused_offset_bits;

    // Word index is offset[18:2]; byte lane and bits above the SRAM are dropped.
    assign offset             = address - 32'(BASE_ADDR);
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};

    // -----------------------------------------------------------------------
    // State register and request latch
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
            if (state == IDLE && (wr_en || rd_en)) begin
                idx_q      <= offset[18:2];
                wdata_q    <= write_data;
                is_write_q <= wr_en;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        case (state)
            IDLE: begin
                if (wr_en || rd_en) begin
                    state_nxt = ACC_LO;
                end
            end
            ACC_LO: begin
                state_nxt = ACC_HI;
            end
            ACC_HI: begin
                cnt_nxt = CNT_W'(WAIT_CYCLES);
                if (WAIT_CYCLES == 0) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                cnt_nxt = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // SRAM interface decode
    // -----------------------------------------------------------------------
    always_comb begin
        in_acc    = 1'b0;
        hi_sel    = 1'b0;
        SRAM_ADDR = last_addr_q;
        dq_oe     = 1'b0;
        dq_out    = wdata_q[15:0];
        if (state == ACC_LO || state == ACC_HI) begin
            in_acc    = 1'b1;
            hi_sel    = (state == ACC_HI);
            SRAM_ADDR = {idx_q, hi_sel};
            dq_oe     = is_write_q;
            dq_out    = hi_sel ? wdata_q[31:16] : wdata_q[15:0];
        end
    end

    assign SRAM_WE_N = ~dq_oe;
    assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;

    // SRAM_ADDR is decoded combinationally; this register remembers the last
    // driven address so the bus stays stable between accesses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_addr_q <= '0;
        end else if (in_acc) begin
            last_addr_q <= SRAM_ADDR;
        end
    end

    // -----------------------------------------------------------------------
    // Read data capture at the closing edge of each read halfword cycle
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read_data <= '0;
        end else if (in_acc && !is_write_q) begin
            if (hi_sel) begin
                read_data[31:16] <= SRAM_DQ;
            end else begin
                read_data[15:0] <= SRAM_DQ;
            end
        end
    end

    assign ready = ~(wr_en | rd_en) | (state == DONE);

endmodule

// File: tb/tb_sram_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_controller
//
// Directed bench for sram_controller. Two instances: one with the default
// WAIT_CYCLES=2, one with WAIT_CYCLES=0. Each has a simple asynchronous SRAM
// model that drives the bus whenever the write strobe is high and stores the
// bus value on a clock edge while the strobe is low. Inputs change 1 ns after
// the rising edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sram_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic mem_clear;

    // default instance (WAIT_CYCLES = 2)
    logic        wr_en, rd_en;
    logic [31:0] address, write_data, read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] mem [0:1023];

    // zero-wait instance (WAIT_CYCLES = 0)
    logic        wr_z, rd_z;
    logic [31:0] address_z, write_data_z, read_data_z;
    logic        ready_z;
    wire  [15:0] sram_dq_z;
    logic [17:0] sram_addr_z;
    logic        sram_we_n_z;
    logic [15:0] mem_z [0:1023];

    int total = 0;
    int bad   = 0;

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
        .address(address), .write_data(write_data), .read_data(read_data),
        .ready(ready), .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr),
        .SRAM_WE_N(sram_we_n)
    );

    sram_controller #(.BASE_ADDR(1024), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .wr_en(wr_z), .rd_en(rd_z),
        .address(address_z), .write_data(write_data_z), .read_data(read_data_z),
        .ready(ready_z), .SRAM_DQ(sram_dq_z), .SRAM_ADDR(sram_addr_z),
        .SRAM_WE_N(sram_we_n_z)
    );

    // SRAM models: output enabled whenever not writing; memory preset to
    // 0x1000 + index so untouched locations are recognisable.
    assign sram_dq   = sram_we_n   ? mem[sram_addr[9:0]]     : 16'bz;
    assign sram_dq_z = sram_we_n_z ? mem_z[sram_addr_z[9:0]] : 16'bz;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i]   <= 16'h1000 + 16'(i);
                mem_z[i] <= 16'h1000 + 16'(i);
            end
        end else begin
            if (!sram_we_n)   mem[sram_addr[9:0]]     <= sram_dq;
            if (!sram_we_n_z) mem_z[sram_addr_z[9:0]] <= sram_dq_z;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; mem_clear = 1'b1;
        wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        wr_z = 1'b0; rd_z = 1'b0; address_z = '0; write_data_z = '0;
        next_cycle();
        mem_clear = 1'b0;

        // ---- reset state ----
        @(negedge clk);
        check_val("rst_ready",   ready,     1);
        check_val("rst_we_n",    sram_we_n, 1);
        check_val("rst_rdata",   read_data, 0);
        check_val("rst_addr",    sram_addr, 0);
        check_val("rst_dq",      sram_dq,   16'h1000);
        check_val("rst_ready_z", ready_z,   1);
        rst = 1'b1;
        next_cycle();

        // ---- write 0xDEADBEEF to 1024 ----
        wr_en = 1'b1; address = 1024; write_data = 32'hDEADBEEF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_val("wr_ready", ready,     (c == 5));
            check_val("wr_we_n",  sram_we_n, !(c == 1 || c == 2));
            if (c == 1) begin
                check_val("wr_lo_dq",   sram_dq,   16'hBEEF);
                check_val("wr_lo_addr", sram_addr, 0);
            end
            if (c == 2) begin
                check_val("wr_hi_dq",   sram_dq,   16'hDEAD);
                check_val("wr_hi_addr", sram_addr, 1);
            end
            next_cycle();
        end
        wr_en = 1'b0;
        @(negedge clk);
        check_val("wr_mem0",      mem[0],    16'hBEEF);
        check_val("wr_mem1",      mem[1],    16'hDEAD);
        check_val("wr_rdata",     read_data, 0);
        check_val("wr_idle_rdy",  ready,     1);
        check_val("wr_addr_hold", sram_addr, 1);
        check_val("wr_dq_release", sram_dq,  16'hDEAD);
        next_cycle();

        // ---- read 1024 ----
        rd_en = 1'b1; address = 1024;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_val("rd_ready", ready,     (c == 5));
            check_val("rd_we_n",  sram_we_n, 1);
            if (c == 1) check_val("rd_lo_addr", sram_addr, 0);
            next_cycle();
        end
        rd_en = 1'b0;
        @(negedge clk);
        check_val("rd_data", read_data, 32'hDEADBEEF);
        next_cycle();

        // ---- back-to-back write 1028 then read 1028 ----
        wr_en = 1'b1; address = 1028; write_data = 32'h12345678;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_val("b2b_wr_ready", ready, (c == 5));
            next_cycle();
        end
        wr_en = 1'b0; rd_en = 1'b1;
        for (int c = 6; c < 12; c++) begin
            @(negedge clk);
            check_val("b2b_rd_ready", ready, (c == 11));
            if (c == 7) begin
                check_val("b2b_rd_addr", sram_addr, 2);
                check_val("b2b_rd_we_n", sram_we_n, 1);
            end
            next_cycle();
        end
        rd_en = 1'b0;
        @(negedge clk);
        check_val("b2b_rdata", read_data, 32'h12345678);
        check_val("b2b_mem2",  mem[2],    16'h5678);
        check_val("b2b_mem3",  mem[3],    16'h1234);
        next_cycle();

        // ---- wr+rd together, address/data changed mid-access ----
        wr_en = 1'b1; rd_en = 1'b1; address = 1032; write_data = 32'hCAFEF00D;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_val("both_ready", ready,     (c == 5));
            check_val("both_we_n",  sram_we_n, !(c == 1 || c == 2));
            if (c == 1) check_val("both_lo_addr", sram_addr, 4);
            if (c == 2) check_val("both_hi_addr", sram_addr, 5);
            next_cycle();
            if (c == 0) begin
                address = 1024; write_data = 32'h0;
            end
        end
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk);
        check_val("both_mem4",  mem[4],    16'hF00D);
        check_val("both_mem5",  mem[5],    16'hCAFE);
        check_val("both_mem0",  mem[0],    16'hBEEF);
        check_val("both_rdata", read_data, 32'h12345678);
        next_cycle();

        // ---- index wrap: BASE + 0x80000 (+3 byte offset) maps to word 0 ----
        wr_en = 1'b1; address = 32'h0008_0403; write_data = 32'hA5A55A5A;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) check_val("wrap_lo_addr", sram_addr, 0);
            if (c == 2) check_val("wrap_hi_addr", sram_addr, 1);
            next_cycle();
        end
        wr_en = 1'b0;
        @(negedge clk);
        check_val("wrap_mem0", mem[0], 16'h5A5A);
        check_val("wrap_mem1", mem[1], 16'hA5A5);
        next_cycle();

        // ---- address below BASE wraps: offset 0xFFFFFC00 -> halfword 0x3FE00 ----
        rd_en = 1'b1; address = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) check_val("neg_lo_addr", sram_addr, 18'h3FE00);
            next_cycle();
        end
        rd_en = 1'b0;
        @(negedge clk);
        check_val("neg_rdata", read_data, 32'h12011200);
        next_cycle();

        // ---- WAIT_CYCLES = 0: write, DONE in cycle 3 ----
        wr_z = 1'b1; address_z = 1040; write_data_z = 32'h77776666;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_val("z_wr_ready", ready_z,     (c == 3));
            check_val("z_wr_we_n",  sram_we_n_z, !(c == 1 || c == 2));
            next_cycle();
        end
        wr_z = 1'b0;
        @(negedge clk);
        check_val("z_mem8", mem_z[8], 16'h6666);
        check_val("z_mem9", mem_z[9], 16'h7777);
        next_cycle();

        rd_z = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_val("z_rd_ready", ready_z, (c == 3));
            next_cycle();
        end
        rd_z = 1'b0;
        @(negedge clk);
        check_val("z_rdata", read_data_z, 32'h77776666);
        next_cycle();

        // ---- WAIT_CYCLES = 0: reset asserted during ACC_HI of a write ----
        wr_z = 1'b1; address_z = 1048; write_data_z = 32'h33334444;
        next_cycle();                       // cycle 1: ACC_LO
        @(negedge clk);
        check_val("zr_lo_we_n", sram_we_n_z, 0);
        check_val("zr_lo_addr", sram_addr_z, 12);
        next_cycle();                       // cycle 2: ACC_HI
        check_val("zr_hi_we_n", sram_we_n_z, 0);
        check_val("zr_hi_addr", sram_addr_z, 13);
        #1;
        rst = 1'b0;
        #1;
        check_val("zr_we_n",  sram_we_n_z, 1);
        check_val("zr_rdata", read_data_z, 0);
        check_val("zr_addr",  sram_addr_z, 0);
        check_val("zr_ready_req", ready_z, 0);
        wr_z = 1'b0;
        #1;
        check_val("zr_ready_idle", ready_z, 1);
        @(negedge clk);
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        check_val("zr_mem12", mem_z[12], 16'h4444);
        check_val("zr_mem13", mem_z[13], 16'h100D);
        check_val("zr_idle_we_n", sram_we_n_z, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
